// File: rtl/resp_misr_checker.sv
// Response analyser: compacts a core's response stream into a Galois MISR over a
// programmed sample window and compares the final signature with a golden value.
module resp_misr_checker #(
    parameter int unsigned          DATA_W = 6,
    parameter int unsigned          SIG_W  = 16,
    parameter int unsigned          CNT_W  = 16,
    parameter logic [SIG_W-1:0]     POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]     SEED   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              pass,
    output logic              fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state_q;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ncyc_q;
    logic [SIG_W-1:0]   gold_q;
    logic               busy_q, done_q, pass_q, fail_q;

    // Galois MISR step with the response word folded into the low bits.
    always_comb begin
        sig_d = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ {{(SIG_W-DATA_W){1'b0}}, resp_data};
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            ncyc_q  <= '0;
            gold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ncyc_q <= num_cycles;
                        gold_q <= golden_sig;
                        sig_q  <= SEED;
                        cnt_q  <= '0;
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (num_cycles == '0) begin
                            state_q <= REPORT;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == ncyc_q) begin
                            state_q <= REPORT;
                            done_q  <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    pass_q  <= (sig_q == gold_q);
                    fail_q  <= (sig_q != gold_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign signature   = sig_q;
    assign cycle_count = cnt_q;
    assign pass        = pass_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_resp_misr_checker.sv
// Bench for resp_misr_checker: table of directed sessions with hand-computed
// signatures, plus sequences for reset mid-run and start while busy.
module tb_resp_misr_checker;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_cycles;
    logic [15:0] golden_sig;
    logic        resp_valid;
    logic [5:0]  resp_data;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] cycle_count;
    logic        pass;
    logic        fail;

    int unsigned checks = 0;
    int unsigned errors = 0;

    resp_misr_checker #(
        .DATA_W (6),
        .SIG_W  (16),
        .CNT_W  (16),
        .POLY   (16'h1021),
        .SEED   (16'hFFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_cycles  (num_cycles),
        .golden_sig  (golden_sig),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy),
        .done        (done),
        .signature   (signature),
        .cycle_count (cycle_count),
        .pass        (pass),
        .fail        (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] gold;
        logic [23:0] data;     // sample i in bits [6*i +: 6]
        logic        gaps;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] d);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ 16'h1021;
        return r ^ {10'd0, d};
    endfunction

    task automatic run_vec(input vec_t v);
        start      = 1'b1;
        num_cycles = v.n;
        golden_sig = v.gold;
        resp_valid = 1'b0;
        tick();
        start      = 1'b0;
        num_cycles = 16'h0003;
        golden_sig = ~v.gold;
        chk("busy_after_start", busy, 1);
        chk("pass_cleared", pass, 0);
        chk("fail_cleared", fail, 0);
        chk("count_cleared", cycle_count, 0);
        for (int i = 0; i < int'(v.n); i++) begin
            resp_valid = 1'b1;
            resp_data  = v.data[i*6 +: 6];
            tick();
            if (i != int'(v.n) - 1) begin
                chk("no_early_done", done, 0);
                if (v.gaps) begin
                    resp_valid = 1'b0;
                    resp_data  = 6'h2A;
                    tick();
                    chk("gap_count_hold", cycle_count, 32'(i + 1));
                end
            end
        end
        chk("done_pulse", done, 1);
        chk("busy_in_report", busy, 1);
        chk("count_final", cycle_count, v.n);
        resp_valid = 1'b1;
        resp_data  = 6'h15;
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("sig_final", signature, v.exp_sig);
        chk("pass", pass, v.exp_pass);
        chk("fail", fail, !v.exp_pass);
        tick();
        chk("sig_ignore_idle", signature, v.exp_sig);
        chk("fail_sticky", fail, !v.exp_pass);
        resp_valid = 1'b0;
    endtask

    vec_t        vecs[7];
    logic [15:0] model;
    logic [5:0]  d;

    initial begin
        vecs[0] = '{n:16'd1, gold:16'hEFDE, data:24'h000001, gaps:1'b0, exp_sig:16'hEFDE, exp_pass:1'b1};
        vecs[1] = '{n:16'd0, gold:16'hFFFF, data:24'h000000, gaps:1'b0, exp_sig:16'hFFFF, exp_pass:1'b1};
        vecs[2] = '{n:16'd4, gold:16'h0E1D, data:{6'h04,6'h03,6'h02,6'h01}, gaps:1'b1, exp_sig:16'h0E1D, exp_pass:1'b1};
        vecs[3] = '{n:16'd4, gold:16'h0E1D, data:{6'h04,6'h03,6'h02,6'h01}, gaps:1'b0, exp_sig:16'h0E1D, exp_pass:1'b1};
        vecs[4] = '{n:16'd1, gold:16'hEFDF, data:24'h000001, gaps:1'b0, exp_sig:16'hEFDE, exp_pass:1'b0};
        vecs[5] = '{n:16'd2, gold:16'h0000, data:{12'd0,6'h00,6'h3F}, gaps:1'b1, exp_sig:16'hCFE1, exp_pass:1'b0};
        vecs[6] = '{n:16'd0, gold:16'h1234, data:24'h000000, gaps:1'b0, exp_sig:16'hFFFF, exp_pass:1'b0};

        reset      = 1'b1;
        start      = 1'b1;
        num_cycles = 16'd5;
        golden_sig = 16'hABCD;
        resp_valid = 1'b1;
        resp_data  = 6'h3F;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", signature, 16'hFFFF);
        chk("rst_count", cycle_count, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        reset      = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k]);
            tick();
        end

        // Reset after 2 of 8 samples
        start      = 1'b1;
        num_cycles = 16'd8;
        golden_sig = 16'h0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1;
            resp_data  = 6'(i + 7);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sig", signature, 16'hFFFF);
        chk("midrst_count", cycle_count, 0);
        chk("midrst_passfail", {pass, fail}, 0);
        for (int i = 0; i < 8; i++) begin
            resp_valid = 1'b1;
            resp_data  = 6'h11;
            tick();
            chk("midrst_no_done", done, 0);
        end
        chk("midrst_sig_idle", signature, 16'hFFFF);
        resp_valid = 1'b0;

        // Start pulse while an 8-sample session is running
        model = 16'hFFFF;
        for (int i = 0; i < 8; i++) model = misr_step(model, 6'((i * 5 + 1) & 63));
        start      = 1'b1;
        num_cycles = 16'd8;
        golden_sig = model;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d          = 6'((i * 5 + 1) & 63);
            resp_valid = 1'b1;
            resp_data  = d;
            if (i == 3) begin
                start      = 1'b1;
                num_cycles = 16'd1;
                golden_sig = 16'h0000;
            end
            tick();
            start = 1'b0;
            if (i != 7) chk("busy_no_restart", {busy, done}, 2'b10);
        end
        chk("busy_run_done", done, 1);
        chk("busy_run_count", cycle_count, 8);
        chk("busy_run_sig", signature, model);
        resp_valid = 1'b1;
        resp_data  = 6'h3F;
        tick();
        resp_valid = 1'b0;
        chk("busy_run_pass", {pass, fail}, 2'b10);
        chk("busy_run_sig_hold", signature, model);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
